// File: rtl/output_buffer.sv
// output_buffer - packs multiplier result chunks into full sets held in a ring
// and hands each completed set to write-back as one wide word.
module output_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_OF_MUL  = 16,
    parameter int DATA_OF_SET = 128,
    parameter int NUM_OF_SET  = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wen,
    input  logic [NUM_OF_MUL-1:0][DATA_WIDTH-1:0]    din,
    input  logic                                     flush,
    input  logic                                     ren,
    output logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]   dout,
    output logic                                     dout_valid,
    output logic                                     full_flag,
    output logic                                     empty_flag,
    output logic [$clog2(NUM_OF_SET+1)-1:0]          set_count
);
    localparam int CHUNKS  = DATA_OF_SET / NUM_OF_MUL;
    localparam int PTR_W   = (NUM_OF_SET > 1) ? $clog2(NUM_OF_SET) : 1;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int CNT_W   = $clog2(NUM_OF_SET + 1);

    typedef logic [CHUNKS-1:0][NUM_OF_MUL-1:0][DATA_WIDTH-1:0] set_t;

    set_t                                   mem_q [NUM_OF_SET];
    logic [PTR_W-1:0]                       wr_set_q, wr_set_d;
    logic [PTR_W-1:0]                       rd_set_q, rd_set_d;
    logic [CHUNK_W-1:0]                     chunk_idx_q, chunk_idx_d;
    logic [CNT_W-1:0]                       set_count_q, set_count_d;
    logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] dout_q, dout_d;
    logic                                   dout_valid_q, dout_valid_d;

    logic wr_acc, rd_acc, flush_acc, complete;

    assign empty_flag = (set_count_q == '0);
    assign full_flag  = (set_count_q == CNT_W'(NUM_OF_SET));

    assign wr_acc    = wen && !full_flag;
    assign rd_acc    = ren && !empty_flag;
    // A flush also closes a set when it arrives together with its first chunk.
    assign flush_acc = flush && !full_flag && ((chunk_idx_q != '0) || wen);
    assign complete  = (wr_acc && (chunk_idx_q == CHUNK_W'(CHUNKS - 1))) || flush_acc;

    always_comb begin
        wr_set_d     = wr_set_q;
        rd_set_d     = rd_set_q;
        chunk_idx_d  = chunk_idx_q;
        set_count_d  = set_count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        if (complete) begin
            chunk_idx_d = '0;
            wr_set_d    = (wr_set_q == PTR_W'(NUM_OF_SET - 1)) ? '0 : wr_set_q + 1'b1;
        end else if (wr_acc) begin
            chunk_idx_d = chunk_idx_q + 1'b1;
        end

        if (rd_acc) begin
            dout_d       = mem_q[rd_set_q];
            dout_valid_d = 1'b1;
            rd_set_d     = (rd_set_q == PTR_W'(NUM_OF_SET - 1)) ? '0 : rd_set_q + 1'b1;
        end

        if (complete && !rd_acc) begin
            set_count_d = set_count_q + 1'b1;
        end else if (rd_acc && !complete) begin
            set_count_d = set_count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_set_q     <= '0;
            rd_set_q     <= '0;
            chunk_idx_q  <= '0;
            set_count_q  <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_set_q     <= wr_set_d;
            rd_set_q     <= rd_set_d;
            chunk_idx_q  <= chunk_idx_d;
            set_count_q  <= set_count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage carries no reset; a set is only readable once it has been completed.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHUNKS; c++) begin
            if (wr_acc && (chunk_idx_q == CHUNK_W'(c))) begin
                mem_q[wr_set_q][c] <= din;
            end else if (flush_acc && (chunk_idx_q <= CHUNK_W'(c))) begin
                mem_q[wr_set_q][c] <= '0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign set_count  = set_count_q;

endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer - directed stimulus with a scoreboard queue of expected popped sets.
module tb_output_buffer;
    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   wen = 1'b0;
    logic                   flush = 1'b0;
    logic                   ren = 1'b0;
    logic [15:0][31:0]      din = '0;
    logic [127:0][31:0]     dout;
    logic                   dout_valid;
    logic                   full_flag;
    logic                   empty_flag;
    logic [1:0]             set_count;

    typedef logic [127:0][31:0] set_t;
    set_t exp_q[$];
    int   ncmp = 0;
    int   nerr = 0;

    output_buffer #(.DATA_WIDTH(32), .NUM_OF_MUL(16), .DATA_OF_SET(128), .NUM_OF_SET(2)) dut (
        .clk(clk), .rst(rst), .wen(wen), .din(din), .flush(flush), .ren(ren),
        .dout(dout), .dout_valid(dout_valid), .full_flag(full_flag),
        .empty_flag(empty_flag), .set_count(set_count)
    );

    always #5 clk = ~clk;

    function automatic set_t mk(input int base, input int nchunks);
        set_t s;
        s = '0;
        for (int i = 0; i < nchunks * 16; i++) s[i] = 32'(base + i);
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int base, input int k);
        wen = 1'b1;
        for (int j = 0; j < 16; j++) din[j] = 32'(base + k * 16 + j);
        tick();
        wen = 1'b0;
    endtask

    task automatic fill(input int base, input int nchunks);
        for (int k = 0; k < nchunks; k++) put(base, k);
    endtask

    task automatic pop(input set_t e);
        exp_q.push_back(e);
        ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            ncmp++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_dout_valid: got 1 expected 0");
            end else begin
                set_t e;
                e = exp_q.pop_front();
                for (int i = 0; i < 128; i++) begin
                    if (dout[i] !== e[i]) begin
                        nerr++;
                        $display("FAIL dout_word[%0d]: got %0d expected %0d", i, dout[i], e[i]);
                        break;
                    end
                end
            end
        end
    end

    initial begin
        // T1 reset
        #12;
        check("rst_empty", int'(empty_flag), 1);
        check("rst_full", int'(full_flag), 0);
        check("rst_count", int'(set_count), 0);
        check("rst_dout_zero", int'(dout == '0), 1);
        check("rst_dout_valid", int'(dout_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T2 pack one set
        fill(0, 8);
        check("t2_count", int'(set_count), 1);
        check("t2_empty", int'(empty_flag), 0);
        pop(mk(0, 8));
        check("t2_valid_pulse", int'(dout_valid), 1);
        check("t2_empty_after", int'(empty_flag), 1);
        tick();
        check("t2_valid_drop", int'(dout_valid), 0);

        // T3 full, dropped write, pops, read on empty ignored
        fill(1000, 8);
        fill(5000, 8);
        check("t3_full", int'(full_flag), 1);
        check("t3_count2", int'(set_count), 2);
        put(9000, 0);
        check("t3_count_after_drop", int'(set_count), 2);
        pop(mk(1000, 8));
        pop(mk(5000, 8));
        check("t3_empty", int'(empty_flag), 1);
        ren = 1'b1; tick(); ren = 1'b0;
        check("t3_read_empty_count", int'(set_count), 0);
        fill(200, 8);
        pop(mk(200, 8));

        // T4 flush partial, idle flush, flush with wen
        fill(300, 3);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t4_count", int'(set_count), 1);
        pop(mk(300, 3));
        flush = 1'b1; tick(); flush = 1'b0;
        check("t4_idle_flush_count", int'(set_count), 0);
        check("t4_idle_flush_empty", int'(empty_flag), 1);
        fill(400, 2);
        flush = 1'b1; put(400, 2); flush = 1'b0;
        check("t4_flush_wen_count", int'(set_count), 1);
        pop(mk(400, 3));

        // T5 concurrent read with write while full, then read with completing write
        fill(600, 8);
        fill(700, 8);
        check("t5_full", int'(full_flag), 1);
        exp_q.push_back(mk(600, 8));
        ren = 1'b1; flush = 1'b1; put(9999, 0); ren = 1'b0; flush = 1'b0;
        check("t5_count_after_full_rw", int'(set_count), 1);
        fill(800, 7);
        exp_q.push_back(mk(700, 8));
        ren = 1'b1; put(800, 7); ren = 1'b0;
        check("t5_count_rw", int'(set_count), 1);
        pop(mk(800, 8));
        check("t5_empty", int'(empty_flag), 1);

        // T6 asynchronous reset mid-set
        fill(900, 8);
        fill(950, 5);
        check("t6_pre_count", int'(set_count), 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_count", int'(set_count), 0);
        check("t6_async_empty", int'(empty_flag), 1);
        check("t6_async_full", int'(full_flag), 0);
        check("t6_async_dout", int'(dout == '0), 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        fill(1100, 8);
        check("t6_clean_count", int'(set_count), 1);
        pop(mk(1100, 8));

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        if (exp_q.size() != 0) begin
            ncmp++;
            nerr++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
